// File: rtl/ibus_dbus_arbiter.sv
// Shares one downstream bus between a fetch (ibus) and a load/store (dbus) requester, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise dbus wins ties.
module ibus_dbus_arbiter (
  input  logic        clk,
  input  logic        resetn,

  input  logic        ireq_valid_i,
  input  logic [31:0] ireq_addr_i,
  input  logic [2:0]  ireq_size_i,
  input  logic [3:0]  ireq_strobe_i,
  input  logic [31:0] ireq_data_i,
  output logic        iresp_addr_ok_o,
  output logic        iresp_data_ok_o,
  output logic [31:0] iresp_data_o,

  input  logic        dreq_valid_i,
  input  logic [31:0] dreq_addr_i,
  input  logic [2:0]  dreq_size_i,
  input  logic [3:0]  dreq_strobe_i,
  input  logic [31:0] dreq_data_i,
  output logic        dresp_addr_ok_o,
  output logic        dresp_data_ok_o,
  output logic [31:0] dresp_data_o,

  output logic        oreq_valid_o,
  output logic [31:0] oreq_addr_o,
  output logic [2:0]  oreq_size_o,
  output logic [3:0]  oreq_strobe_o,
  output logic [31:0] oreq_data_o,
  input  logic        oresp_addr_ok_i,
  input  logic        oresp_data_ok_i,
  input  logic [31:0] oresp_data_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t tie_winner;
  owner_t pick;
  owner_t cur_owner;
  logic   send;
  logic   addr_hs;
  logic   data_hs;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when the most recent accepted address belonged to dbus
  logic last_d_q, last_d_d;
  assign tie_winner = last_d_q ? OWN_I : OWN_D;
`else
  assign tie_winner = OWN_D;
`endif

  always_comb begin
    pick = OWN_NONE;
    if (ireq_valid_i && dreq_valid_i) begin
      pick = tie_winner;
    end else if (dreq_valid_i) begin
      pick = OWN_D;
    end else if (ireq_valid_i) begin
      pick = OWN_I;
    end
  end

  // Owner is chosen live while idle and frozen once granted
  assign cur_owner = (state_q == S_IDLE) ? pick : owner_q;
  assign send      = resetn && (state_q != S_DATA) && (cur_owner != OWN_NONE);
  assign addr_hs   = send && oresp_addr_ok_i;
  assign data_hs   = resetn && oresp_data_ok_i && ((state_q == S_DATA) || addr_hs);

  always_comb begin
    oreq_valid_o  = 1'b0;
    oreq_addr_o   = 32'h0;
    oreq_size_o   = 3'h0;
    oreq_strobe_o = 4'h0;
    oreq_data_o   = 32'h0;
    if (send) begin
      if (cur_owner == OWN_I) begin
        oreq_valid_o  = ireq_valid_i;
        oreq_addr_o   = ireq_addr_i;
        oreq_size_o   = ireq_size_i;
        oreq_strobe_o = ireq_strobe_i;
        oreq_data_o   = ireq_data_i;
      end else begin
        oreq_valid_o  = dreq_valid_i;
        oreq_addr_o   = dreq_addr_i;
        oreq_size_o   = dreq_size_i;
        oreq_strobe_o = dreq_strobe_i;
        oreq_data_o   = dreq_data_i;
      end
    end
  end

  always_comb begin
    iresp_addr_ok_o = addr_hs && (cur_owner == OWN_I);
    iresp_data_ok_o = data_hs && (cur_owner == OWN_I);
    iresp_data_o    = iresp_data_ok_o ? oresp_data_i : 32'h0;
    dresp_addr_ok_o = addr_hs && (cur_owner == OWN_D);
    dresp_data_ok_o = data_hs && (cur_owner == OWN_D);
    dresp_data_o    = dresp_data_ok_o ? oresp_data_i : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
    if (addr_hs) begin
      last_d_d = (cur_owner == OWN_D);
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (cur_owner != OWN_NONE) begin
          owner_d = cur_owner;
          if (addr_hs) begin
            state_d = data_hs ? S_IDLE : S_DATA;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (addr_hs) begin
          state_d = data_hs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (data_hs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
    // A completed transaction releases ownership so the next IDLE cycle can re-arbitrate
    if (data_hs) begin
      owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Self-checking bench for ibus_dbus_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level reference model.
module tb_ibus_dbus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        iv, dv;
  logic [31:0] ia, id, da, dd;
  logic [2:0]  isz, dsz;
  logic [3:0]  ist, dst;
  logic        iao, ido, dao, ddo;
  logic [31:0] idat, ddat;
  logic        ov;
  logic [31:0] oa, od;
  logic [2:0]  osz;
  logic [3:0]  ost;
  logic        rao, rdo;
  logic [31:0] rdat;

  ibus_dbus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid_i(iv), .ireq_addr_i(ia), .ireq_size_i(isz), .ireq_strobe_i(ist), .ireq_data_i(id),
    .iresp_addr_ok_o(iao), .iresp_data_ok_o(ido), .iresp_data_o(idat),
    .dreq_valid_i(dv), .dreq_addr_i(da), .dreq_size_i(dsz), .dreq_strobe_i(dst), .dreq_data_i(dd),
    .dresp_addr_ok_o(dao), .dresp_data_ok_o(ddo), .dresp_data_o(ddat),
    .oreq_valid_o(ov), .oreq_addr_o(oa), .oreq_size_o(osz), .oreq_strobe_o(ost), .oreq_data_o(od),
    .oresp_addr_ok_i(rao), .oresp_data_ok_i(rdo), .oresp_data_i(rdat)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one optional in-flight transaction record (who owns it, address accepted yet)
  bit  m_busy = 0;
  bit  m_acc  = 0;
  int  m_who  = 0;   // 1 = ibus, 2 = dbus
  int  m_last = 1;   // requester given the most recent accepted address
  logic [71:0] e_oreq;
  logic [33:0] e_i, e_d;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   who;
    bit   send, ao_w, do_w;
    logic [33:0] resp;
    e_oreq = '0; e_i = '0; e_d = '0;
    ao_w = 0; do_w = 0;
    if (!resetn) begin
      m_busy = 0; m_acc = 0; m_who = 0; m_last = 1;
      return;
    end
    who = 0;
    send = 0;
    if (!m_busy) begin
      if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
        who = (m_last == 1) ? 2 : 1;
`else
        who = 2;
`endif
      end else if (dv) who = 2;
      else if (iv) who = 1;
      send = (who != 0);
    end else begin
      who  = m_who;
      send = !m_acc;
    end
    if (send) begin
      e_oreq = (who == 1) ? {iv, ia, isz, ist, id} : {dv, da, dsz, dst, dd};
      m_who = who;
      if (rao) begin
        ao_w = 1;
        m_last = who;
        if (rdo) begin
          do_w = 1; m_busy = 0; m_acc = 0;
        end else begin
          m_busy = 1; m_acc = 1;
        end
      end else begin
        m_busy = 1; m_acc = 0;
      end
    end else if (m_busy && rdo) begin
      do_w = 1; m_busy = 0; m_acc = 0;
    end
    resp = {ao_w, do_w, do_w ? rdat : 32'h0};
    if (who == 1) e_i = resp;
    else if (who == 2) e_d = resp;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    chk("oreq",  {ov, oa, osz, ost, od}, e_oreq);
    chk("iresp", {38'h0, iao, ido, idat}, {38'h0, e_i});
    chk("dresp", {38'h0, dao, ddo, ddat}, {38'h0, e_d});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iv = 0; ia = 0; isz = 0; ist = 0; id = 0;
    dv = 0; da = 0; dsz = 0; dst = 0; dd = 0;
    rao = 0; rdo = 0; rdat = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    tick();
    chk("rst_outputs", {ov, iao, ido, dao, ddo, idat, ddat}, 72'h0);
    adv();
    tick();
    adv();
    resetn = 1;
    tick();
    chk("post_rst_outputs", {ov, iao, ido, dao, ddo, idat, ddat}, 72'h0);
    adv();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  bit got_i, got_d;

  initial begin
    resetn = 0;
    idle_inputs();

    // Single fetch, SRAM-style downstream
    do_reset();
    iv = 1; ia = 32'h1000; isz = 3'd2; rao = 1;
    tick();
    chk("r028_c0_iaddr_ok", iao, 1);
    chk("r028_c0_oaddr", oa, 32'h1000);
    chk("r028_c0_dresp", {dao, ddo, ddat}, 0);
    adv();
    iv = 0; rdo = 1; rdat = 32'hDEADBEEF;
    tick();
    chk("r028_c1_idata", {ido, idat}, {1'b1, 32'hDEADBEEF});
    chk("r028_c1_dresp", {dao, ddo, ddat}, 0);
    adv();
    idle_inputs();

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed-priority tie: dbus first, ibus granted after one idle cycle
    do_reset();
    iv = 1; ia = 32'h2000; dv = 1; da = 32'h3000; rao = 1;
    tick();
    chk("r029_c0_grant", {iao, dao}, 2'b01);
    chk("r029_c0_oaddr", oa, 32'h3000);
    adv();
    dv = 0; rdo = 1; rdat = 32'h11111111;
    tick();
    chk("r029_c1_ddata", {ddo, ddat}, {1'b1, 32'h11111111});
    chk("r029_c1_no_grant", {ov, iao}, 2'b00);
    adv();
    rdo = 0;
    tick();
    chk("r029_c2_iaddr_ok", iao, 1);
    chk("r029_c2_oaddr", oa, 32'h2000);
    adv();
    iv = 0; rdo = 1; rdat = 32'h22222222;
    tick();
    chk("r029_c3_idata", {ido, idat}, {1'b1, 32'h22222222});
    adv();
    idle_inputs();
`else
    // Round-robin with both requesters always valid: d, i, d, i
    do_reset();
    iv = 1; ia = 32'h2000; dv = 1; da = 32'h3000; rao = 1;
    for (int k = 0; k < 8; k++) begin
      rdo = k[0];
      tick();
      chk("r030_grant", {iao, dao}, k[0] ? 2'b00 : (k[1] ? 2'b10 : 2'b01));
      adv();
    end
    idle_inputs();
`endif

    // Address stall on dbus must lock out ibus
    do_reset();
    dv = 1; da = 32'h4000; dd = 32'h5555AAAA; iv = 1; ia = 32'h5000;
    for (int k = 0; k < 4; k++) begin
      rao = (k == 3);
      tick();
      chk("r031_oaddr", oa, 32'h4000);
      chk("r031_addr_ok", {iao, dao}, (k == 3) ? 2'b01 : 2'b00);
      adv();
    end
    dv = 0; iv = 0; rdo = 1;
    tick();
    adv();
    idle_inputs();

    // Reset during the data phase abandons the transaction
    do_reset();
    iv = 1; ia = 32'h6000; rao = 1;
    tick();
    chk("r032_c0_iaddr_ok", iao, 1);
    adv();
    iv = 0; rao = 0; resetn = 0;
    tick();
    chk("r032_c1_resp", {iao, ido, dao, ddo}, 4'h0);
    adv();
    resetn = 1; rdo = 1; rdat = 32'hBADBAD00;
    tick();
    chk("r032_c2_resp", {iao, ido, idat, dao, ddo, ddat}, 68'h0);
    adv();
    iv = 1; ia = 32'h7000; rao = 1; rdo = 0;
    tick();
    chk("r032_c3_idle_grant", iao, 1);
    adv();
    iv = 0; rdo = 1;
    tick();
    adv();
    idle_inputs();

    // Same-cycle addr_ok and data_ok on a store
    do_reset();
    dv = 1; da = 32'h8000; dst = 4'hF; dd = 32'hCAFEF00D; rao = 1; rdo = 1;
    tick();
    chk("r033_c0_dresp", {dao, ddo}, 2'b11);
    chk("r033_c0_ostrobe", {ost, od}, {4'hF, 32'hCAFEF00D});
    adv();
    dv = 0; dst = 0; iv = 1; ia = 32'h9000; rdo = 0;
    tick();
    chk("r033_c1_next_grant", iao, 1);
    adv();
    iv = 0; rdo = 1;
    tick();
    adv();
    idle_inputs();

    // Randomized traffic against the model
    do_reset();
    got_i = 0; got_d = 0;
    for (int n = 0; n < 4000; n++) begin
      resetn = ($urandom_range(0, 149) != 0);
      rao  = ($urandom_range(0, 9) < 7);
      rdo  = $urandom_range(0, 1);
      rdat = $urandom;
      if (!iv || got_i) begin
        iv = ($urandom_range(0, 4) < 2);
        ia = $urandom; isz = 3'($urandom_range(0, 2)); ist = 4'h0; id = $urandom;
      end
      if (!dv || got_d) begin
        dv = ($urandom_range(0, 4) < 2);
        da = $urandom; dsz = 3'($urandom_range(0, 2)); dst = 4'($urandom); dd = $urandom;
      end
      tick();
      got_i = e_i[33];
      got_d = e_d[33];
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
